// File: rtl/pipe_stage_chain.sv
// Valid/ready register chain of STAGES slots with global stall, per-stage flush
// and either bubble-collapsing (COLLAPSE=1) or lockstep (COLLAPSE=0) advance.
module pipe_stage_chain #(
    parameter int DATA_W   = 32,
    parameter int STAGES   = 2,
    parameter int COLLAPSE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    input  logic                       stall,
    input  logic [STAGES-1:0]          flush,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0]   valid;
    logic [STAGES-1:0]   valid_nxt;
    logic [STAGES-1:0]   adv;
    logic [STAGES:0]     src_valid;
    logic [DATA_W-1:0]   data     [STAGES];
    logic [DATA_W-1:0]   src_data [STAGES+1];
    logic [OCC_W-1:0]    occ_q;
    logic [OCC_W-1:0]    occ_nxt;

    // Advance enables are resolved from the output side back toward the input,
    // carrying the downstream enable in a scalar to avoid a self-referencing vector.
    always_comb begin
        logic adv_top;
        logic chain;
        adv     = '0;
        adv_top = ~stall & (~valid[STAGES-1] | out_ready);
        chain   = adv_top;
        adv[STAGES-1] = adv_top;
        for (int unsigned i = 1; i < STAGES; i++) begin
            if (COLLAPSE != 0) begin
                chain = ~stall & (~valid[STAGES-1-i] | chain);
            end else begin
                chain = adv_top;
            end
            adv[STAGES-1-i] = chain;
        end
    end

    // Source of stage k is entry k of these: upstream port for k=0, stage k-1 otherwise.
    always_comb begin
        src_valid   = {valid, in_valid};
        src_data[0] = in_data;
        for (int unsigned k = 0; k < STAGES; k++) begin
            src_data[k+1] = data[k];
        end
    end

    always_comb begin
        valid_nxt = valid;
        occ_nxt   = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (flush[k]) begin
                valid_nxt[k] = 1'b0;
            end else if (adv[k]) begin
                valid_nxt[k] = src_valid[k];
            end
            occ_nxt = occ_nxt + OCC_W'(valid_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            occ_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                data[k] <= '0;
            end
        end else begin
            valid <= valid_nxt;
            occ_q <= occ_nxt;
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (adv[k] && src_valid[k]) begin
                    data[k] <= src_data[k];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid[STAGES-1] & ~stall;
    assign out_data  = data[STAGES-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed vector bench for pipe_stage_chain: 3-stage collapsing, 3-stage lockstep
// and 1-stage instances share the upstream/downstream stimulus.
module tb_pipe_stage_chain;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       stall = 1'b0;
    logic [2:0] flush3 = '0;
    logic [0:0] flush1 = '0;

    logic       ir_a, ov_a, ir_l, ov_l, ir_1, ov_1;
    logic [7:0] od_a, od_l, od_1;
    logic [1:0] occ_a, occ_l;
    logic [0:0] occ_1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_stage_chain #(.DATA_W(8), .STAGES(3), .COLLAPSE(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_a), .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready),
        .stall(stall), .flush(flush3), .occupancy(occ_a)
    );

    pipe_stage_chain #(.DATA_W(8), .STAGES(3), .COLLAPSE(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_l), .out_valid(ov_l), .out_data(od_l), .out_ready(out_ready),
        .stall(stall), .flush(flush3), .occupancy(occ_l)
    );

    pipe_stage_chain #(.DATA_W(8), .STAGES(1), .COLLAPSE(1)) dut_1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(ir_1), .out_valid(ov_1), .out_data(od_1), .out_ready(out_ready),
        .stall(stall), .flush(flush1), .occupancy(occ_1)
    );

    typedef struct {
        bit         rst;
        int         sel;   // 0: collapsing 3-stage, 1: lockstep 3-stage, 2: 1-stage
        bit         iv;
        logic [7:0] d;
        bit         ordy;
        bit         st;
        logic [2:0] fl;
        bit         e_ir;
        bit         e_ov;
        logic [7:0] e_od;
        int         e_occ;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input int sel, input bit iv, input logic [7:0] d,
                       input bit ordy, input bit st, input logic [2:0] fl,
                       input bit e_ir, input bit e_ov, input logic [7:0] e_od, input int e_occ);
        vec_t v;
        v.rst = rst; v.sel = sel; v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        int ir, ov, od, occ;
        if (v.rst) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
        end
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        stall     = v.st;
        flush3    = v.fl;
        flush1    = v.fl[0];
        #1;
        case (v.sel)
            0:       begin ir = int'(ir_a); ov = int'(ov_a); od = int'(od_a); occ = int'(occ_a); end
            1:       begin ir = int'(ir_l); ov = int'(ov_l); od = int'(od_l); occ = int'(occ_l); end
            default: begin ir = int'(ir_1); ov = int'(ov_1); od = int'(od_1); occ = int'(occ_1); end
        endcase
        chk("in_ready", idx, ir, int'(v.e_ir));
        chk("out_valid", idx, ov, int'(v.e_ov));
        chk("out_data", idx, od, int'(v.e_od));
        chk("occupancy", idx, occ, v.e_occ);
    endtask

    initial begin
        // fill/drain, out_ready=1
        add(1,0,1,8'hA,1,0,0, 1,0,8'h0,0);
        add(0,0,1,8'hB,1,0,0, 1,0,8'h0,1);
        add(0,0,1,8'hC,1,0,0, 1,0,8'h0,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'hA,3);
        add(0,0,0,8'h0,1,0,0, 1,1,8'hB,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'hC,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'hC,0);
        // backpressure with bubble collapse
        add(1,0,1,8'h1,0,0,0, 1,0,8'h0,0);
        add(0,0,0,8'h0,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'h2,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'h3,0,0,0, 1,1,8'h1,2);
        add(0,0,0,8'h0,0,0,0, 0,1,8'h1,3);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h1,3);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h2,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h3,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'h3,0);
        // lockstep: only last stage valid blocks input
        add(1,1,1,8'h1,0,0,0, 1,0,8'h0,0);
        add(0,1,0,8'h0,0,0,0, 1,0,8'h0,1);
        add(0,1,0,8'h0,0,0,0, 1,0,8'h0,1);
        add(0,1,1,8'h2,0,0,0, 0,1,8'h1,1);
        add(0,1,1,8'h2,1,0,0, 1,1,8'h1,1);
        add(0,1,0,8'h0,1,0,0, 1,0,8'h1,1);
        add(0,1,0,8'h0,1,0,0, 1,0,8'h1,1);
        add(0,1,0,8'h0,1,0,0, 1,1,8'h2,1);
        // stall with two entries, then stall masking a valid output
        add(1,0,1,8'h4,0,0,0, 1,0,8'h0,0);
        add(0,0,1,8'h5,0,0,0, 1,0,8'h0,1);
        add(0,0,0,8'h0,0,1,0, 0,0,8'h0,2);
        add(0,0,1,8'h9,0,1,0, 0,0,8'h0,2);
        add(0,0,0,8'h0,0,0,0, 1,0,8'h0,2);
        add(0,0,0,8'h0,1,1,0, 0,0,8'h4,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h4,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h5,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'h5,0);
        // flush 3'b011 with out_ready=1
        add(1,0,1,8'h7,0,0,0, 1,0,8'h0,0);
        add(0,0,1,8'h6,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'h5,0,0,0, 1,0,8'h0,2);
        add(0,0,1,8'h8,1,0,3, 1,1,8'h7,3);
        add(0,0,0,8'h0,0,0,0, 1,1,8'h6,1);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h6,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'h6,0);
        // flush 3'b011 with out_ready=0
        add(1,0,1,8'h7,0,0,0, 1,0,8'h0,0);
        add(0,0,1,8'h6,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'h5,0,0,0, 1,0,8'h0,2);
        add(0,0,1,8'h8,0,0,3, 0,1,8'h7,3);
        add(0,0,0,8'h0,0,0,0, 1,1,8'h7,1);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h7,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'h7,0);
        // flush of the output stage while stalled
        add(1,0,1,8'h7,0,0,0, 1,0,8'h0,0);
        add(0,0,1,8'h6,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'h5,0,0,0, 1,0,8'h0,2);
        add(0,0,1,8'h8,0,1,4, 0,0,8'h7,3);
        add(0,0,0,8'h0,0,0,0, 1,0,8'h7,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h6,2);
        add(0,0,0,8'h0,1,0,0, 1,1,8'h5,1);
        add(0,0,0,8'h0,1,0,0, 1,0,8'h5,0);
        // single-stage register
        add(1,2,1,8'h11,0,0,0, 1,0,8'h00,0);
        add(0,2,1,8'h22,0,0,0, 0,1,8'h11,1);
        add(0,2,1,8'h22,1,0,0, 1,1,8'h11,1);
        add(0,2,0,8'h00,1,1,0, 0,0,8'h22,1);
        add(0,2,0,8'h00,1,0,0, 1,1,8'h22,1);
        add(0,2,0,8'h00,1,0,0, 1,0,8'h22,0);
        // prefix for the asynchronous reset sequence (fills the chain)
        add(1,0,1,8'hA,0,0,0, 1,0,8'h0,0);
        add(0,0,1,8'hB,0,0,0, 1,0,8'h0,1);
        add(0,0,1,8'hC,0,0,0, 1,0,8'h0,2);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset mid-cycle on a full chain, no clock edge in between.
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_reset_occ", 0, int'(occ_a), 3);
        chk("pre_reset_out_valid", 0, int'(ov_a), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 0, int'(ov_a), 0);
        chk("async_occupancy", 0, int'(occ_a), 0);
        chk("async_out_data", 0, int'(od_a), 0);
        chk("async_in_ready", 0, int'(ir_a), 1);
        stall = 1'b1;
        #1;
        chk("reset_stall_in_ready", 0, int'(ir_a), 0);
        stall = 1'b0;

        begin
            vec_t post[4];
            post[0] = '{1,0,1,8'hE,1,0,3'd0, 1,0,8'h0,0};
            post[1] = '{0,0,0,8'h0,1,0,3'd0, 1,0,8'h0,1};
            post[2] = '{0,0,0,8'h0,1,0,3'd0, 1,0,8'h0,1};
            post[3] = '{0,0,0,8'h0,1,0,3'd0, 1,1,8'hE,1};
            for (int i = 0; i < 4; i++) begin
                apply(post[i], 1000 + i);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 SHALL have parameter DATA_W, default 32: payload width in bits, legal range 1..256.
REQ-002 SHALL have parameter STAGES, default 2: number of register stages, legal range 1..8; stage 0 is the input side and stage STAGES-1 is the output side.
REQ-003 SHALL have parameter COLLAPSE, default 1: 1 lets a stage advance into an empty slot downstream; 0 shifts all stages together.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-008 SHALL have port in_ready, output, 1 bit: stage 0 accepts this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit: stage STAGES-1 presents a valid payload.
REQ-010 SHALL have port out_data, output, DATA_W bits: payload of stage STAGES-1.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes this cycle.
REQ-012 SHALL have port stall, input, 1 bit: global freeze.
REQ-013 SHALL have port flush, input, STAGES bits: per-stage kill; bit k targets stage k.
REQ-014 SHALL have port occupancy, output, $clog2(STAGES+1) bits: count of valid stages.

Function
REQ-015 SHALL keep one valid bit and one DATA_W data register per stage.
REQ-016 SHALL compute the advance enables combinationally:
- adv[STAGES-1] = ~stall & (~valid[STAGES-1] | out_ready).
- When COLLAPSE=1: adv[k] = ~stall & (~valid[k] | adv[k+1]).
- When COLLAPSE=0: adv[k] = adv[STAGES-1] for every k.
REQ-017 SHALL drive in_ready = adv[0]; in_ready SHALL NOT depend on in_valid or flush.
REQ-018 SHALL drive out_valid = valid[STAGES-1] & ~stall.
REQ-019 SHALL drive out_data = data[STAGES-1] at all times.
REQ-020 SHALL apply the stage update when adv[k]=1:
- Stage k loads the valid bit of its source (in_valid for stage 0, valid[k-1] otherwise).
- Stage k loads its source data only when the source valid is 1; otherwise the data register holds.
REQ-021 SHALL make a stage with adv[k]=0 hold both its valid bit and its data.
REQ-022 SHALL clear valid[k] at the edge whenever flush[k]=1, overriding REQ-020 and REQ-021, including while stall=1.
- Any entry moving into stage k on that edge is discarded.
- The upstream handshake (in_valid & in_ready) still counts as accepted.
REQ-023 SHALL let the entry leaving stage k toward stage k+1 on a flush[k] edge proceed unless flush[k+1]=1.
REQ-024 SHALL treat in_valid & in_ready as a transfer in and out_valid & out_ready as a transfer out; latency from an accepted input to out_valid is STAGES cycles when the chain is unobstructed.
REQ-025 SHALL preserve order; no payload is duplicated, and none is lost except by flush.
REQ-026 SHALL register occupancy as the popcount of the valid bits after each edge, so it is consistent with valid[].
REQ-027 SHALL make the 1-stage configuration act as a single skid-free register: in_ready = ~stall & (~valid | out_ready).
REQ-028 SHALL handle simultaneous in and out transfers on a full chain with no bubble insertion when COLLAPSE=1 or COLLAPSE=0.

Reset
REQ-029 SHALL, while rst_n=0 and without waiting for a clock edge, clear:
- every valid bit;
- every data register to 0;
- occupancy to 0;
- out_valid to 0.
REQ-030 SHALL drive in_ready = ~stall during reset and on the first cycle after release.
REQ-031 SHALL discard in-flight entries when reset asserts mid-operation; nothing is replayed.
REQ-032 SHALL accept its first input on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL check fill/drain (STAGES=3, out_ready=1):
- Stimulus: accept 0xA, 0xB, 0xC on consecutive cycles.
- Response: out_data 0xA on cycle 3, 0xB on cycle 4, 0xC on cycle 5; occupancy peaks at 3.
REQ-034 SHALL check backpressure/collapse (STAGES=3, out_ready=0, COLLAPSE=1):
- Stimulus: push 0x1, idle one cycle, push 0x2 and 0x3.
- Response: the bubble collapses; in_ready falls after the third accept; occupancy=3; on release, drain order is 0x1, 0x2, 0x3.
REQ-035 SHALL check lockstep (STAGES=3, COLLAPSE=0):
- Stimulus: only stage 2 valid, out_ready=0.
- Response: in_ready=0 although stages 0 and 1 are empty.
REQ-036 SHALL check stall:
- Stimulus: stall=1 for 2 cycles with occupancy=2.
- Response: in_ready=0 and out_valid=0; valid bits and data unchanged; after stall drops, order is preserved.
REQ-037 SHALL check flush (STAGES=3, all stages holding 0x5, 0x6, 0x7):
- Stimulus: flush=3'b011 together with in_valid=1 and in_data=0x8.
- Response: 0x8 is accepted and dropped; 0x6 moves to stage 2 and 0x7 exits if out_ready=1, else occupancy=1 holding 0x7.
REQ-038 SHALL check asynchronous reset:
- Stimulus: rst_n pulled low mid-cycle with occupancy=3.
- Response: out_valid=0 and occupancy=0 immediately, with no clock edge; the first post-release input appears at the output 3 cycles later.
